board_writer: RTL and testbench
===============================

Name: board_writer

Overview:
- Write-side counterpart of the falling-piece logic. The falling piece reads the board for collision checks; this block owns the board and writes to it.
- On a lock request it merges the four cells of the stopped piece into the settled board.
- It then scans the board bottom-up and clears full rows, shifting the rows above down by one.
- It reports the number of lines cleared and a sticky game-over flag. It sits between the game-control FSM and the renderer, and drives the `board` array that the falling-piece logic consumes.

Parameters:
- ROWS, 20, number of visible board rows; row 0 is the bottom row.
- COLS, 10, number of columns; bit x of a row is column x.
- XW, 5, width of x coordinates.
- YW, 6, width of y coordinates.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- lock_req  in  1  single-cycle pulse: lock the piece at x0..x3 / y0..y3 into the board.
- clear_req  in  1  single-cycle pulse: wipe the board for a new game.
- x0, x1, x2, x3  in  XW each  column of each piece cell.
- y0, y1, y2, y3  in  YW each  row of each piece cell.
- board  out  COLS x ROWS (unpacked [ROWS])  settled board, registered.
- busy  out  1  high from the cycle after lock acceptance until done.
- done  out  1  one-cycle pulse when merge and clear have finished.
- lines_cleared  out  3  rows cleared by the last lock, 0..4; valid from done, held until the next done.
- total_lines  out  16  saturating running total of cleared rows.
- game_over  out  1  sticky top-out flag.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - board all zero, state IDLE, busy=0, done=0.
  - lines_cleared=0, total_lines=0, game_over=0.
  - Reset asserted mid-operation aborts the operation immediately; no done pulse is issued.
- States: IDLE, MERGE, SCAN, DONE.
- IDLE:
  - clear_req=1: board zeroed and game_over cleared on that edge; total_lines is kept. Stay in IDLE.
  - Else lock_req=1: latch all eight coordinates, go to MERGE, busy=1 from the next cycle.
  - clear_req has priority over a simultaneous lock_req; the lock is dropped.
- MERGE (1 cycle):
  - For each cell i with y_i<ROWS and x_i<COLS, set board[y_i][x_i]=1 (OR-in; overlap is not an error).
  - Any cell with y_i>=ROWS is discarded and sets game_over=1.
  - Any cell with x_i>=COLS is discarded silently.
  - Reset the row pointer r=0 and the clear count k=0, then go to SCAN.
- SCAN (one row per cycle):
  - If board[r] is all ones: every row j>=r takes the value of row j+1, the top row becomes zero, k increments, and r is unchanged (the new row r is re-examined next cycle).
  - Otherwise r increments.
  - Go to DONE when a non-full row is found at r==ROWS-1, or when a clear is performed at r==ROWS-1.
  - k saturates at 4; a 5th full row is not possible with one piece, but the clear is still performed.
- DONE (1 cycle):
  - done=1, busy=0.
  - lines_cleared=k.
  - total_lines += k, saturating at 16'hFFFF.
  - Go to IDLE.
- Latency:
  - With no clears, done is asserted 22 cycles after the accepting edge (1 MERGE + ROWS SCAN + 1 DONE).
  - Each cleared row adds 1 cycle.
- lock_req while busy is ignored.
- clear_req while busy aborts the operation: board zeroed, game_over cleared, return to IDLE, no done pulse, lines_cleared unchanged.
- Coordinates are sampled only at acceptance; input changes during busy have no effect.
- All outputs are registered.

Decomposition:
- tetris_pkg holds:
  - constants BOARD_ROWS=20, BOARD_COLS=10, COORD_XW=5, COORD_YW=6;
  - typedef row_t = logic [BOARD_COLS-1:0];
  - typedef board_t = row_t [BOARD_ROWS];
  - enum bw_state_e {BW_IDLE, BW_MERGE, BW_SCAN, BW_DONE}.
- One natural sub-module, board_row_collapse: combinational; inputs a board and a row index r; outputs the board with row r removed and a zero row inserted at the top. It keeps the shift network out of the FSM.

Test Plan:
1. Reset, then lock an I piece at x=3..6, y=0 → done 22 cycles after the accepting edge; board[0]=10'b0001111000; lines_cleared=0; game_over=0.
2. Preload row 0 = 10'b1111110000 via prior locks, then lock I at x=6..9, y=0 → board[0] zero, rows above shifted down; lines_cleared=1; total_lines increments by 1; done at 23 cycles.
3. Build rows 0..3 full except column 9, then lock a vertical I at x=9, y=0..3 → lines_cleared=4; board all zero; done at 26 cycles.
4. Lock an O piece with y=19,20 → cells in row 19 written, row 20 discarded, game_over=1; then clear_req → board zero, game_over=0, total_lines unchanged.
5. Assert clear_req and lock_req in the same IDLE cycle → board zeroed, no busy, no done. Then lock_req at SCAN r=5 followed by clear_req → abort, no done pulse.
6. Drop reset_n asynchronously mid-SCAN → all outputs return to reset values immediately; a lock issued after reset completes normally.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry, row/board types and board-writer FSM states.
package tetris_pkg;

  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned COORD_XW   = 5;
  localparam int unsigned COORD_YW   = 6;

  typedef logic [BOARD_COLS-1:0] row_t;
  typedef row_t board_t [BOARD_ROWS];

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_MERGE,
    BW_SCAN,
    BW_DONE
  } bw_state_e;

endpackage

// File: rtl/board_row_collapse.sv
// Removes row r from a board, drops every higher row by one and zero-fills the top row.
module board_row_collapse #(
  parameter int unsigned ROWS = 20,
  parameter int unsigned COLS = 10,
  parameter int unsigned RW   = $clog2(ROWS)
) (
  input  logic [COLS-1:0] board_in  [ROWS],
  input  logic [RW-1:0]   r,
  output logic [COLS-1:0] board_out [ROWS]
);

  always_comb begin
    for (int j = 0; j < ROWS; j++) begin
      board_out[j] = board_in[j];
      if (RW'(j) >= r) begin
        if (j == ROWS - 1) board_out[j] = '0;
        else               board_out[j] = board_in[j+1];
      end
    end
  end

endmodule

// File: rtl/board_writer.sv
// Owns the settled board: merges a locked piece, then collapses full rows bottom-up.
module board_writer
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS = BOARD_ROWS,
  parameter int unsigned COLS = BOARD_COLS,
  parameter int unsigned XW   = COORD_XW,
  parameter int unsigned YW   = COORD_YW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          lock_req,
  input  logic          clear_req,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [XW-1:0] x2,
  input  logic [XW-1:0] x3,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [YW-1:0] y2,
  input  logic [YW-1:0] y3,
  output logic [COLS-1:0] board [ROWS],
  output logic          busy,
  output logic          done,
  output logic [2:0]    lines_cleared,
  output logic [15:0]   total_lines,
  output logic          game_over
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  bw_state_e       state;
  logic [XW-1:0]   lx [4];
  logic [YW-1:0]   ly [4];
  logic [RW-1:0]   r;
  logic [2:0]      k;
  logic [COLS-1:0] merged_c    [ROWS];
  logic [COLS-1:0] collapsed_c [ROWS];
  logic            top_out_c;
  logic            row_full_c;
  logic [16:0]     total_sum_c;

  // Merge the latched piece; off-board rows flag a top-out, off-board columns are dropped.
  always_comb begin
    merged_c  = board;
    top_out_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ly[i] >= YW'(ROWS)) begin
        top_out_c = 1'b1;
      end else if (lx[i] < XW'(COLS)) begin
        merged_c[ly[i][RW-1:0]][lx[i][CW-1:0]] = 1'b1;
      end
    end
  end

  assign row_full_c  = &board[r];
  assign total_sum_c = 17'(total_lines) + 17'(k);

  board_row_collapse #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_collapse (
    .board_in  (board),
    .r         (r),
    .board_out (collapsed_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= BW_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
      game_over     <= 1'b0;
      r             <= '0;
      k             <= '0;
      for (int j = 0; j < ROWS; j++) board[j] <= '0;
      for (int i = 0; i < 4; i++) begin
        lx[i] <= '0;
        ly[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      // A wipe wins in every state and silently abandons any lock in flight.
      if (clear_req) begin
        for (int j = 0; j < ROWS; j++) board[j] <= '0;
        game_over <= 1'b0;
        busy      <= 1'b0;
        state     <= BW_IDLE;
      end else begin
        case (state)
          BW_IDLE: begin
            if (lock_req) begin
              lx[0] <= x0; lx[1] <= x1; lx[2] <= x2; lx[3] <= x3;
              ly[0] <= y0; ly[1] <= y1; ly[2] <= y2; ly[3] <= y3;
              busy  <= 1'b1;
              state <= BW_MERGE;
            end
          end
          BW_MERGE: begin
            board <= merged_c;
            if (top_out_c) game_over <= 1'b1;
            r     <= '0;
            k     <= '0;
            state <= BW_SCAN;
          end
          BW_SCAN: begin
            // After a collapse the same r is re-examined, as new contents dropped into it.
            if (row_full_c) begin
              board <= collapsed_c;
              if (k != 3'd4) k <= k + 3'd1;
              if (r == RW'(ROWS - 1)) state <= BW_DONE;
            end else if (r == RW'(ROWS - 1)) begin
              state <= BW_DONE;
            end else begin
              r <= r + RW'(1);
            end
          end
          BW_DONE: begin
            done          <= 1'b1;
            busy          <= 1'b0;
            lines_cleared <= k;
            total_lines   <= total_sum_c[16] ? 16'hFFFF : total_sum_c[15:0];
            state         <= BW_IDLE;
          end
          default: state <= BW_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: locks, row clears, top-out, wipes, aborts and async reset.
module tb_board_writer;

  logic        clk;
  logic        reset_n;
  logic        lock_req;
  logic        clear_req;
  logic [4:0]  x0, x1, x2, x3;
  logic [5:0]  y0, y1, y2, y3;
  logic [9:0]  board [20];
  logic        busy;
  logic        done;
  logic [2:0]  lines_cleared;
  logic [15:0] total_lines;
  logic        game_over;

  int n_tests;
  int n_fail;
  int lat;
  logic done_seen;
  logic [9:0] acc;

  board_writer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .lock_req      (lock_req),
    .clear_req     (clear_req),
    .x0            (x0),
    .x1            (x1),
    .x2            (x2),
    .x3            (x3),
    .y0            (y0),
    .y1            (y1),
    .y2            (y2),
    .y3            (y3),
    .board         (board),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse lock_req for one cycle, then count edges until done is seen (999 on timeout).
  task automatic do_lock(input logic [4:0] a0, a1, a2, a3,
                         input logic [5:0] b0, b1, b2, b3, output int l);
    @(negedge clk);
    x0 = a0; x1 = a1; x2 = a2; x3 = a3;
    y0 = b0; y1 = b1; y2 = b2; y3 = b3;
    lock_req = 1'b1;
    @(posedge clk);
    #1 lock_req = 1'b0;
    x0 = 5'd31; y0 = 6'd63;
    l = 999;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    clk = 1'b0; reset_n = 1'b0; lock_req = 1'b0; clear_req = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    y0 = '0; y1 = '0; y2 = '0; y3 = '0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_total", 32'(total_lines), 0);
    check("rst_row0", 32'(board[0]), 0);
    @(negedge clk) reset_n = 1'b1;

    // 1: horizontal I at x=3..6, y=0
    do_lock(5'd3, 5'd4, 5'd5, 5'd6, 6'd0, 6'd0, 6'd0, 6'd0, lat);
    check("t1_latency", 32'(lat), 22);
    check("t1_row0", 32'(board[0]), 32'h078);
    check("t1_lines", 32'(lines_cleared), 0);
    check("t1_game_over", 32'(game_over), 0);
    check("t1_busy_at_done", 32'(busy), 0);
    @(posedge clk); #1;
    check("t1_done_one_cycle", 32'(done), 0);

    // 2: preload row0=1111110000, row1=0000110000, then fill cols 0..3
    pulse_clear();
    do_lock(5'd6, 5'd7, 5'd8, 5'd9, 6'd0, 6'd0, 6'd0, 6'd0, lat);
    do_lock(5'd4, 5'd5, 5'd4, 5'd5, 6'd0, 6'd0, 6'd1, 6'd1, lat);
    check("t2_pre_row0", 32'(board[0]), 32'h3F0);
    check("t2_pre_row1", 32'(board[1]), 32'h030);
    do_lock(5'd0, 5'd1, 5'd2, 5'd3, 6'd0, 6'd0, 6'd0, 6'd0, lat);
    check("t2_latency", 32'(lat), 23);
    check("t2_row0", 32'(board[0]), 32'h030);
    check("t2_row1", 32'(board[1]), 0);
    check("t2_lines", 32'(lines_cleared), 1);
    check("t2_total", 32'(total_lines), 1);

    // 3: rows 0..3 full except col 9, then vertical I at col 9 clears four
    pulse_clear();
    for (int r = 0; r < 4; r++) begin
      do_lock(5'd0, 5'd1, 5'd2, 5'd3, 6'(r), 6'(r), 6'(r), 6'(r), lat);
      do_lock(5'd4, 5'd5, 5'd6, 5'd7, 6'(r), 6'(r), 6'(r), 6'(r), lat);
    end
    do_lock(5'd8, 5'd8, 5'd8, 5'd8, 6'd0, 6'd1, 6'd2, 6'd3, lat);
    check("t3_pre_row3", 32'(board[3]), 32'h1FF);
    check("t3_pre_lines", 32'(lines_cleared), 0);
    do_lock(5'd9, 5'd9, 5'd9, 5'd9, 6'd0, 6'd1, 6'd2, 6'd3, lat);
    check("t3_latency", 32'(lat), 26);
    check("t3_lines", 32'(lines_cleared), 4);
    check("t3_total", 32'(total_lines), 5);
    acc = '0;
    for (int j = 0; j < 20; j++) acc = acc | board[j];
    check("t3_board_empty", 32'(acc), 0);

    // 4: O piece straddling the top, then wipe
    do_lock(5'd4, 5'd5, 5'd4, 5'd5, 6'd19, 6'd19, 6'd20, 6'd20, lat);
    check("t4_latency", 32'(lat), 22);
    check("t4_row19", 32'(board[19]), 32'h030);
    check("t4_game_over", 32'(game_over), 1);
    pulse_clear();
    check("t4_wipe_row19", 32'(board[19]), 0);
    check("t4_wipe_game_over", 32'(game_over), 0);
    check("t4_wipe_total", 32'(total_lines), 5);

    // 5a: simultaneous clear and lock in IDLE
    do_lock(5'd0, 5'd1, 5'd2, 5'd3, 6'd5, 6'd5, 6'd5, 6'd5, lat);
    check("t5_pre_row5", 32'(board[5]), 32'h00F);
    @(negedge clk);
    x0 = 5'd0; x1 = 5'd1; x2 = 5'd2; x3 = 5'd3;
    y0 = 6'd0; y1 = 6'd0; y2 = 6'd0; y3 = 6'd0;
    clear_req = 1'b1; lock_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0; lock_req = 1'b0;
    check("t5a_row5", 32'(board[5]), 0);
    check("t5a_busy", 32'(busy), 0);
    done_seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      done_seen = done_seen | done | busy;
    end
    check("t5a_no_activity", 32'(done_seen), 0);
    check("t5a_row0", 32'(board[0]), 0);

    // 5b: lock, abort with clear while scanning row 5
    @(negedge clk);
    x0 = 5'd0; x1 = 5'd1; x2 = 5'd2; x3 = 5'd3;
    lock_req = 1'b1;
    @(posedge clk);
    #1 lock_req = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("t5b_busy_mid", 32'(busy), 1);
    check("t5b_row0_merged", 32'(board[0]), 32'h00F);
    pulse_clear();
    check("t5b_busy_abort", 32'(busy), 0);
    check("t5b_row0", 32'(board[0]), 0);
    done_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      done_seen = done_seen | done;
    end
    check("t5b_no_done", 32'(done_seen), 0);
    check("t5b_lines", 32'(lines_cleared), 0);

    // 6: asynchronous reset mid-scan
    @(negedge clk);
    x0 = 5'd0; x1 = 5'd1; x2 = 5'd2; x3 = 5'd3;
    y0 = 6'd0; y1 = 6'd0; y2 = 6'd0; y3 = 6'd0;
    lock_req = 1'b1;
    @(posedge clk);
    #1 lock_req = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_row0", 32'(board[0]), 0);
    check("t6_total", 32'(total_lines), 0);
    check("t6_done", 32'(done), 0);
    @(negedge clk) reset_n = 1'b1;
    do_lock(5'd2, 5'd3, 5'd4, 5'd5, 6'd1, 6'd1, 6'd1, 6'd1, lat);
    check("t6_latency", 32'(lat), 22);
    check("t6_row1", 32'(board[1]), 32'h03C);
    check("t6_lines", 32'(lines_cleared), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
